snake_engine: RTL
=================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 Parameters SHALL be: TICK_CYCLES, default 1000000, clocks between moves; MAX_LEN, default 200, body ring depth; INIT_LEN, default 5, starting length.
REQ-002 vga_clk  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; asserting it forces the reset state immediately.
REQ-004 up, right, down, left  in  1 each  level direction requests, already synchronous to vga_clk.
REQ-005 start  in  1  single-cycle pulse; restarts the game from OVER.
REQ-006 grow  in  1  single-cycle pulse from apple logic; lengthens the snake at the next move.
REQ-007 cell_we  out  1  board write strobe to the frame board RAM read by vga_controller.
REQ-008 cell_addr  out  11  board index, 40*row + col, range 0..1599.
REQ-009 cell_data  out  2  cell value: 0 empty, 1 snake1.
REQ-010 stage  out  2  1 INIT, 2 PLAY, 3 OVER.
REQ-011 length  out  8  current snake length.
REQ-012 step  out  1  one-cycle pulse on every committed move.

Function
REQ-013 States SHALL be INIT_CLR, INIT_PAINT, PLAY, ERASE, HEAD, OVER; stage = 1 in INIT_*, 2 in PLAY/ERASE/HEAD, 3 in OVER.
REQ-014 INIT_CLR SHALL write 0 to addresses 0..1599, one per cycle in ascending order (1600 cycles), and clear the internal 1600-bit occupancy map.
REQ-015 INIT_PAINT SHALL write 1 to row 10, cols 10,9,8,7,6 in that order (head first), fill the ring, set occupancy, set length=INIT_LEN and direction=RIGHT, then enter PLAY.
REQ-016 The direction request SHALL be sampled every cycle with priority up > right > down > left; a request opposite to the current direction SHALL be ignored; the latched request takes effect at the next move only.
REQ-017 The tick counter SHALL run only in PLAY, and SHALL fire when it reaches TICK_CYCLES-1, then wrap to 0.
REQ-018 On a tick, the next head SHALL be computed; a wall crossing (row 0 going up, row 39 going down, col 0 going left, col 39 going right) SHALL go to OVER with no board write and no length change.
REQ-019 ERASE (tick+1): without a pending grow, the engine SHALL write 0 to the tail cell and clear its occupancy; with a pending grow, it SHALL write nothing, increment length (saturating at MAX_LEN, in which case the tail is erased normally), and clear grow_pending.
REQ-020 HEAD (tick+2): if the next-head cell is occupied after the erase, the engine SHALL go to OVER; otherwise it SHALL write 1 to that cell, set occupancy, decrement the head pointer modulo MAX_LEN, store the position, pulse step, and return to PLAY.
REQ-021 Moving into the cell vacated by the tail in the same move SHALL be legal.
REQ-022 The ring SHALL wrap: head pointer 0 decrements to MAX_LEN-1; tail index = (head + length - 1) mod MAX_LEN.
REQ-023 grow SHALL set grow_pending in any state except INIT_*; grow coincident with a tick SHALL apply to that move.
REQ-024 cell_we SHALL be high only in INIT_CLR, INIT_PAINT, ERASE (when erasing) and HEAD (when writing); it is registered, so the write appears one cycle after the decision.
REQ-025 OVER SHALL hold the board unchanged; start SHALL enter INIT_CLR; start in any other state SHALL be ignored.

Reset
REQ-026 On reset the outputs SHALL be: cell_we=0, cell_addr=0, cell_data=0, stage=1, length=INIT_LEN, step=0.
REQ-027 On reset the internal state SHALL be: state INIT_CLR, tick counter 0, direction RIGHT, grow_pending 0, head pointer 0.
REQ-028 Reset asserted mid-move or mid-clear SHALL abandon the operation; the clear restarts from address 0 on release.

Structure
REQ-029 The shared package snake_pkg SHALL hold: board width/height (40), cell encodings, the stage encoding, the direction enum (UP=1, RIGHT=2, DOWN=3, LEFT=4), and the INIT row/col constants.
REQ-030 The body ring SHALL be one sub-module, snake_body_ram: MAX_LEN x 11 bits, one write port and one asynchronous read port.

Verification (TICK_CYCLES=16)
REQ-031 After reset release: 1600 writes of 0, then 5 writes of 1 at 410,409,408,407,406; stage goes 1->2.
REQ-032 No input, first tick: write 0 @406 at tick+1, write 1 @411 at tick+2, step pulse; length stays 5.
REQ-033 left held while moving RIGHT: request ignored, next head 412; then up held: next head 372 (412-40).
REQ-034 grow pulse, then tick: no erase write, head written, length=6; grow coincident with the tick gives the same result.
REQ-035 Drive the head to col 39 moving right: at the next tick stage=3, no cell_we; start pulse -> stage=1 and the clear reruns.
REQ-036 Length-5 snake turning up, left, down onto its own body: stage=3, no head write; reset asserted during ERASE: cell_we=0 immediately, clear restarts at 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake engine: board geometry, cell
// encodings, stage codes, movement directions and the engine state encoding.
package snake_pkg;

    localparam int BOARD_W     = 40;
    localparam int BOARD_H     = 40;
    localparam int BOARD_CELLS = BOARD_W * BOARD_H;
    localparam int ADDR_W      = 11;

    localparam logic [1:0] CELL_EMPTY  = 2'd0;
    localparam logic [1:0] CELL_SNAKE1 = 2'd1;

    localparam logic [1:0] STAGE_INIT = 2'd1;
    localparam logic [1:0] STAGE_PLAY = 2'd2;
    localparam logic [1:0] STAGE_OVER = 2'd3;

    localparam logic [5:0] INIT_ROW = 6'd10;
    localparam logic [5:0] INIT_COL = 6'd10;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_LEFT  = 3'd4
    } dir_t;

    typedef enum logic [2:0] {
        ST_INIT_CLR   = 3'd0,
        ST_INIT_PAINT = 3'd1,
        ST_PLAY       = 3'd2,
        ST_ERASE      = 3'd3,
        ST_HEAD       = 3'd4,
        ST_OVER       = 3'd5
    } state_t;

    // Linear board index: 40*row + col, built from shifts (32 + 8).
    function automatic logic [ADDR_W-1:0] cell_index(input logic [5:0] row, input logic [5:0] col);
        return ({5'd0, row} << 5) + ({5'd0, row} << 3) + {5'd0, col};
    endfunction

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            default:   return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_body_ram.sv
// Body ring: one board position per snake segment, head at the head pointer,
// tail at (head + length - 1) mod depth. Synchronous write, asynchronous read.
module snake_body_ram
    import snake_pkg::*;
#(
    parameter int DEPTH = 200,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              vga_clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    // Single write port, no reset: contents are rebuilt by the paint phase.
    always_ff @(posedge vga_clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: clears and paints the board, then on every tick moves
// the head one cell, erasing the tail unless a grow is pending. Wall or body
// hits end the game. Board writes leave through registered cell_* outputs.
module snake_engine
    import snake_pkg::*;
#(
    parameter int TICK_CYCLES = 1000000,
    parameter int MAX_LEN     = 200,
    parameter int INIT_LEN    = 5
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              up,
    input  logic              right,
    input  logic              down,
    input  logic              left,
    input  logic              start,
    input  logic              grow,
    output logic              cell_we,
    output logic [ADDR_W-1:0] cell_addr,
    output logic [1:0]        cell_data,
    output logic [1:0]        stage,
    output logic [7:0]        length,
    output logic              step,
    output logic [2:0]        dbg_state
);

    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [7:0]        MAX_LEN_L  = 8'(MAX_LEN);
    localparam logic [7:0]        INIT_LEN_L = 8'(INIT_LEN);
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(BOARD_CELLS - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] init_cnt;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    dir_t              cur_dir, req_dir, pick_dir, eff_dir;
    logic              pick_valid;
    logic              grow_pending, grow_applies;
    logic [PW-1:0]     head_ptr, head_ptr_dec, tail_idx;
    logic [15:0]       tail_sum;
    logic [5:0]        head_row, head_col, nxt_row, nxt_col, mv_row, mv_col;
    logic              wall, hit;
    logic [ADDR_W-1:0] mv_addr, paint_addr, tail_pos;
    logic [BOARD_CELLS-1:0] occ;
    logic              wr_en, step_nx, ram_we;
    logic [ADDR_W-1:0] wr_addr, ram_wdata;
    logic [1:0]        wr_data;
    logic [PW-1:0]     ram_waddr;

    assign tick         = (state == ST_PLAY) && (tick_cnt == TW'(TICK_CYCLES - 1));
    assign grow_applies = grow_pending && (length < MAX_LEN_L);
    assign mv_addr      = cell_index(mv_row, mv_col);
    assign paint_addr   = cell_index(INIT_ROW, INIT_COL - init_cnt[5:0]);
    assign hit          = occ[mv_addr];
    assign head_ptr_dec = (head_ptr == '0) ? PW'(MAX_LEN - 1) : head_ptr - PW'(1);
    assign tail_sum     = 16'(head_ptr) + 16'(length) - 16'd1;
    assign tail_idx     = (tail_sum >= 16'(MAX_LEN)) ? PW'(tail_sum - 16'(MAX_LEN)) : PW'(tail_sum);
    // A request is judged against the direction that will be current after this edge.
    assign eff_dir      = tick ? req_dir : cur_dir;
    assign dbg_state    = state;

    snake_body_ram #(.DEPTH(MAX_LEN), .AW(PW)) u_body (
        .vga_clk (vga_clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr   (tail_idx),
        .rdata   (tail_pos)
    );

    // Fixed-priority pick of the direction buttons: up > right > down > left.
    always_comb begin
        pick_valid = 1'b1;
        pick_dir   = DIR_RIGHT;
        if (up)         pick_dir = DIR_UP;
        else if (right) pick_dir = DIR_RIGHT;
        else if (down)  pick_dir = DIR_DOWN;
        else if (left)  pick_dir = DIR_LEFT;
        else            pick_valid = 1'b0;
    end

    // Candidate next head for the latched request, flagging a wall crossing.
    always_comb begin
        nxt_row = head_row;
        nxt_col = head_col;
        wall    = 1'b0;
        case (req_dir)
            DIR_UP:    if (head_row == 6'd0) wall = 1'b1; else nxt_row = head_row - 6'd1;
            DIR_DOWN:  if (head_row == 6'(BOARD_H - 1)) wall = 1'b1; else nxt_row = head_row + 6'd1;
            DIR_LEFT:  if (head_col == 6'd0) wall = 1'b1; else nxt_col = head_col - 6'd1;
            DIR_RIGHT: if (head_col == 6'(BOARD_W - 1)) wall = 1'b1; else nxt_col = head_col + 6'd1;
            default: ;
        endcase
    end

    // Stage code shown to the rest of the system.
    always_comb begin
        case (state)
            ST_INIT_CLR, ST_INIT_PAINT: stage = STAGE_INIT;
            ST_OVER:                    stage = STAGE_OVER;
            default:                    stage = STAGE_PLAY;
        endcase
    end

    // State register.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) state <= ST_INIT_CLR;
        else       state <= state_nx;
    end

    // Next state plus this cycle's board write, ring write and step decision.
    always_comb begin
        state_nx  = state;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = CELL_EMPTY;
        ram_we    = 1'b0;
        ram_waddr = head_ptr;
        ram_wdata = '0;
        step_nx   = 1'b0;
        case (state)
            ST_INIT_CLR: begin
                wr_en   = 1'b1;
                wr_addr = init_cnt;
                if (init_cnt == LAST_CELL) state_nx = ST_INIT_PAINT;
            end
            ST_INIT_PAINT: begin
                wr_en     = 1'b1;
                wr_addr   = paint_addr;
                wr_data   = CELL_SNAKE1;
                ram_we    = 1'b1;
                ram_waddr = PW'(init_cnt);
                ram_wdata = paint_addr;
                if (init_cnt == ADDR_W'(INIT_LEN - 1)) state_nx = ST_PLAY;
            end
            ST_PLAY: begin
                if (tick) state_nx = wall ? ST_OVER : ST_ERASE;
            end
            ST_ERASE: begin
                if (!grow_applies) begin
                    wr_en   = 1'b1;
                    wr_addr = tail_pos;
                end
                state_nx = ST_HEAD;
            end
            ST_HEAD: begin
                if (hit) begin
                    state_nx = ST_OVER;
                end else begin
                    wr_en     = 1'b1;
                    wr_addr   = mv_addr;
                    wr_data   = CELL_SNAKE1;
                    ram_we    = 1'b1;
                    ram_waddr = head_ptr_dec;
                    ram_wdata = mv_addr;
                    step_nx   = 1'b1;
                    state_nx  = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start) state_nx = ST_INIT_CLR;
            end
            default: state_nx = ST_INIT_CLR;
        endcase
    end

    // Registered board-write port and step pulse.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            cell_we   <= 1'b0;
            cell_addr <= '0;
            cell_data <= CELL_EMPTY;
            step      <= 1'b0;
        end else begin
            cell_we   <= wr_en;
            cell_addr <= wr_addr;
            cell_data <= wr_data;
            step      <= step_nx;
        end
    end

    // Game datapath: counters, direction, grow flag, head/ring pointers, occupancy.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            init_cnt     <= '0;
            tick_cnt     <= '0;
            cur_dir      <= DIR_RIGHT;
            req_dir      <= DIR_RIGHT;
            grow_pending <= 1'b0;
            head_ptr     <= '0;
            head_row     <= INIT_ROW;
            head_col     <= INIT_COL;
            mv_row       <= '0;
            mv_col       <= '0;
            length       <= INIT_LEN_L;
            occ          <= '0;
        end else begin
            case (state)
                ST_INIT_CLR:   init_cnt <= (init_cnt == LAST_CELL) ? '0 : init_cnt + ADDR_W'(1);
                ST_INIT_PAINT: init_cnt <= init_cnt + ADDR_W'(1);
                default:       init_cnt <= '0;
            endcase

            if (state == ST_INIT_CLR || state == ST_INIT_PAINT) begin
                cur_dir      <= DIR_RIGHT;
                req_dir      <= DIR_RIGHT;
                grow_pending <= 1'b0;
                tick_cnt     <= '0;
            end else begin
                if (pick_valid && pick_dir != opposite(eff_dir)) req_dir <= pick_dir;
                if (tick) cur_dir <= req_dir;
                // A fresh grow pulse survives the erase that consumes the old one.
                if (grow)                   grow_pending <= 1'b1;
                else if (state == ST_ERASE) grow_pending <= 1'b0;
                if (state == ST_PLAY) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            end

            if (tick) begin
                mv_row <= nxt_row;
                mv_col <= nxt_col;
            end

            case (state)
                ST_INIT_CLR: begin
                    occ      <= '0;
                    head_ptr <= '0;
                end
                ST_INIT_PAINT: begin
                    occ[paint_addr] <= 1'b1;
                    if (init_cnt == ADDR_W'(INIT_LEN - 1)) begin
                        length   <= INIT_LEN_L;
                        head_row <= INIT_ROW;
                        head_col <= INIT_COL;
                    end
                end
                ST_ERASE: begin
                    if (grow_applies) length <= length + 8'd1;
                    else              occ[tail_pos] <= 1'b0;
                end
                ST_HEAD: begin
                    if (!hit) begin
                        occ[mv_addr] <= 1'b1;
                        head_ptr     <= head_ptr_dec;
                        head_row     <= mv_row;
                        head_col     <= mv_col;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
